// File: rtl/chnl_acum_stream.sv
// Channel accumulator: sums CHNL channel planes, streamed column by column, into one output plane.
// Define CHNL_ACUM_SAT_EN to clamp lane sums and raise a sticky per-frame saturation flag.
module chnl_acum_stream #(
    parameter int DW   = 32,
    parameter int AW   = 40,
    parameter int HIT  = 56,
    parameter int WID  = 56,
    parameter int CHNL = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [DW*HIT-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [AW*HIT-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_done,
    output logic              sat_o
);
    localparam int CW = (WID > 1) ? $clog2(WID) : 1;
    localparam int HW = $clog2(CHNL);
    localparam logic [CW-1:0] COL_LAST = CW'(WID - 1);
    localparam logic [HW-1:0] CH_LAST  = HW'(CHNL - 1);

    typedef enum logic [1:0] {PH_FIRST, PH_ACCUM, PH_LAST} phase_e;

    logic [CW-1:0]     col_q, col_d;
    logic [HW-1:0]     ch_q, ch_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [AW*HIT-1:0] out_data_q, out_data_d;
    logic [AW*HIT-1:0] buf_q [WID];
    logic [AW*HIT-1:0] buf_rd, wr_data, sum_all;
    phase_e            phase;
    logic              beat, out_hs;

    always_comb begin
        phase = PH_ACCUM;
        if (ch_q == '0)           phase = PH_FIRST;
        else if (ch_q == CH_LAST) phase = PH_LAST;
    end

    assign in_ready   = (phase != PH_LAST) || !out_valid_q || out_ready;
    assign beat       = in_valid && in_ready && !clr;
    assign out_hs     = out_valid_q && out_ready;
    assign buf_rd     = buf_q[col_q];
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = out_hs && out_last_q;

`ifdef CHNL_ACUM_SAT_EN
    logic [HIT-1:0] lane_ovf;
`endif

    for (genvar k = 0; k < HIT; k++) begin : g_lane
        logic signed [DW-1:0] in_lane;
        logic signed [AW-1:0] ext, acc, sum;
        assign in_lane = in_data[DW*k +: DW];
        assign ext     = AW'(in_lane);
        assign acc     = buf_rd[AW*k +: AW];
`ifdef CHNL_ACUM_SAT_EN
        // One guard bit exposes overflow; clamp towards the sign of the true result.
        logic signed [AW:0] wide;
        assign wide        = (AW+1)'(acc) + (AW+1)'(ext);
        assign lane_ovf[k] = wide[AW] ^ wide[AW-1];
        assign sum = !lane_ovf[k] ? wide[AW-1:0] :
                     wide[AW]     ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
`else
        assign sum = acc + ext;
`endif
        assign sum_all[AW*k +: AW] = sum;
        assign wr_data[AW*k +: AW] = (phase == PH_FIRST) ? ext : sum;
    end

    // NOTE: the column buffer has no reset; a FIRST-phase beat overwrites each entry before it is read.
    always_ff @(posedge clk) begin
        if (beat && phase != PH_LAST) buf_q[col_q] <= wr_data;
    end

    always_comb begin
        col_d       = col_q;
        ch_d        = ch_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        if (clr) begin
            col_d       = '0;
            ch_d        = '0;
            out_valid_d = 1'b0;
        end else begin
            if (out_hs) out_valid_d = 1'b0;
            if (beat) begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                // A LAST beat in the same cycle as an output handshake reloads the register.
                if (phase == PH_LAST) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sum_all;
                    out_last_d  = (col_q == COL_LAST);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only; next-state comes from the always_comb above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            col_q       <= col_d;
            ch_q        <= ch_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef CHNL_ACUM_SAT_EN
    logic sat_q, sat_d;

    always_comb begin
        sat_d = sat_q;
        if (clr) begin
            sat_d = 1'b0;
        end else begin
            if (frame_done) sat_d = 1'b0;
            if (beat && phase != PH_FIRST && |lane_ovf) sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_q <= 1'b0;
        else        sat_q <= sat_d;
    end

    assign sat_o = sat_q;
`else
    assign sat_o = 1'b0;
`endif

endmodule

// File: tb/tb_chnl_acum_stream.sv
// Scoreboard bench for chnl_acum_stream: DW=8, HIT=2, WID=3, CHNL=4, with AW=12 and AW=9 instances.
// Expected sums come from a lane model that wraps or clamps according to CHNL_ACUM_SAT_EN.
module tb_chnl_acum_stream;
    localparam int DW = 8, HIT = 2, WID = 3, CHNL = 4;

    typedef struct {
        int l12[2];
        int l9[2];
        bit last;
        bit sat12;
        bit sat9;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, frame_done, sat_o;
    logic [23:0] out_data;
    logic        in_ready9, out_valid9, frame_done9, sat9;
    logic [17:0] out_data9;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   acc12[WID][HIT];
    int   acc9[WID][HIT];
    int   m_col = 0, m_ch = 0;
    bit   m_sat12 = 0, m_sat9 = 0;
    bit   stall_prev = 0;
    logic [23:0] held;

    always #5 clk = ~clk;

    chnl_acum_stream #(.DW(DW), .AW(12), .HIT(HIT), .WID(WID), .CHNL(CHNL)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_done(frame_done), .sat_o(sat_o)
    );

    chnl_acum_stream #(.DW(DW), .AW(9), .HIT(HIT), .WID(WID), .CHNL(CHNL)) u_dut9 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready9), .out_data(out_data9), .out_valid(out_valid9), .out_ready(out_ready),
        .frame_done(frame_done9), .sat_o(sat9)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int add_lane(input int a, input int b, input int aw, inout bit sat);
        int s, lim;
        s   = a + b;
        lim = 1 << (aw - 1);
`ifdef CHNL_ACUM_SAT_EN
        if (s > lim - 1) begin
            s = lim - 1; sat = 1'b1;
        end else if (s < -lim) begin
            s = -lim; sat = 1'b1;
        end
`else
        s = s & (2 * lim - 1);
        if (s >= lim) s -= 2 * lim;
`endif
        return s;
    endfunction

    task automatic model_accept(input int a, input int b);
        int   v[2];
        int   s12, s9;
        exp_t e;
        v[0] = a;
        v[1] = b;
        e.last = (m_col == WID - 1);
        for (int k = 0; k < HIT; k++) begin
            if (m_ch == 0) begin
                acc12[m_col][k] = v[k];
                acc9[m_col][k]  = v[k];
            end else begin
                s12 = add_lane(acc12[m_col][k], v[k], 12, m_sat12);
                s9  = add_lane(acc9[m_col][k],  v[k], 9,  m_sat9);
                if (m_ch < CHNL - 1) begin
                    acc12[m_col][k] = s12;
                    acc9[m_col][k]  = s9;
                end else begin
                    e.l12[k] = s12;
                    e.l9[k]  = s9;
                end
            end
        end
        if (m_ch == CHNL - 1) begin
            e.sat12 = m_sat12;
            e.sat9  = m_sat9;
            exp_q.push_back(e);
            if (e.last) begin
                m_sat12 = 1'b0;
                m_sat9  = 1'b0;
            end
        end
        if (m_col == WID - 1) begin
            m_col = 0;
            m_ch  = (m_ch == CHNL - 1) ? 0 : m_ch + 1;
        end else begin
            m_col++;
        end
    endtask

    task automatic model_clear();
        m_col   = 0;
        m_ch    = 0;
        m_sat12 = 1'b0;
        m_sat9  = 1'b0;
        exp_q.delete();
    endtask

    // Holds the beat on the bus until the DUT takes it, then updates the model.
    task automatic wait_accept(input int a, input int b, input bit chk_rdy);
        bit done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (chk_rdy && n == 0) check("in_ready_high", in_ready, 1);
            if (in_ready === 1'b1) begin
                model_accept(a, b);
                done = 1'b1;
            end
        end
        if (!done) check("accept_timeout", done, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input int a, input int b, input bit chk_rdy = 1'b0);
        in_data  = {b[7:0], a[7:0]};
        in_valid = 1'b1;
        wait_accept(a, b, chk_rdy);
    endtask

    task automatic frame(input int a, input int b, input bit chk_rdy = 1'b0);
        for (int i = 0; i < WID * CHNL; i++) send(a, b, chk_rdy);
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid) check("hold_data", out_data, held);
            if (out_valid && out_ready) begin
                check("valid_match", out_valid9, 1);
                if (exp_q.size() == 0) begin
                    check("exp_pending", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    for (int k = 0; k < HIT; k++) begin
                        check("out12_lane", $signed(out_data[12*k +: 12]), e.l12[k]);
                        check("out9_lane", $signed(out_data9[9*k +: 9]), e.l9[k]);
                    end
                    check("frame_done", frame_done, e.last);
                    check("frame_done9", frame_done9, e.last);
                    check("sat12", sat_o, e.sat12);
                    check("sat9", sat9, e.sat9);
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = out_data;
        end
    end

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_data9", out_data9, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_sat", sat_o, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All ones, in_ready never drops while downstream is ready.
        frame(1, 1, 1'b1);
        drain();

        // Most negative input in every channel.
        frame(-128, -128);
        drain();

        // Back-to-back frames with no clr; then distinct lane values.
        frame(1, 1);
        frame(2, 2);
        frame(5, -7);
        drain();

        // AW=9 instance overflows at the third channel.
        frame(127, 127);
        drain();

        // Downstream stall during the LAST channel.
        out_ready = 1'b0;
        for (int ch = 0; ch < CHNL; ch++) begin
            for (int col = 0; col < WID; col++) begin
                if (ch == CHNL - 1 && col == 1) begin
                    in_data  = {8'(-(col + 2)), 8'(col + 1)};
                    in_valid = 1'b1;
                    repeat (3) begin
                        @(negedge clk);
                        check("stall_in_ready", in_ready, 0);
                        check("stall_out_valid", out_valid, 1);
                    end
                    @(posedge clk);
                    #1;
                    out_ready = 1'b1;
                    wait_accept(col + 1, -(col + 2), 1'b0);
                end else begin
                    send(col + 1, -(col + 2));
                end
            end
        end
        drain();

        // clr after 5 beats, with a beat offered in the clr cycle.
        for (int i = 0; i < 5; i++) send(3, 3);
        in_data  = {8'd9, 8'd9};
        in_valid = 1'b1;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        model_clear();
        @(negedge clk);
        check("clr_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        frame(1, 1);
        drain();

        // clr while an output is stalled drops it.
        out_ready = 1'b0;
        for (int i = 0; i < WID * (CHNL - 1) + 1; i++) send(2, 2);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_clear();
        @(negedge clk);
        check("clr_stall_valid", out_valid, 0);
        check("clr_stall_sat", sat_o, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        frame(1, 1);
        drain();

        // Asynchronous reset mid-frame with a pending output.
        out_ready = 1'b0;
        for (int i = 0; i < WID * (CHNL - 1) + 1; i++) send(3, 3);
        rst_n = 1'b0;
        #2;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_in_ready", in_ready, 1);
        model_clear();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        frame(1, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chnl_acum_stream.md
CHNL_ACUM_STREAM -- requirements
Module: chnl_acum_stream

Interface
REQ-001 SHALL have parameter DW, default 32: signed width of each input lane.
REQ-002 SHALL have parameter AW, default 40: signed accumulator and output lane width; AW >= DW.
REQ-003 SHALL have parameter HIT, default 56: lanes per column.
REQ-004 SHALL have parameter WID, default 56: columns per channel plane.
REQ-005 SHALL have parameter CHNL, default 64: channels accumulated per output column; CHNL >= 2.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port clr, input, 1: synchronous restart of frame counters.
REQ-009 SHALL have port in_data, input, DW*HIT: one column; lane k is bits [DW*k +: DW].
REQ-010 SHALL have port in_valid, input, 1: in_data is valid.
REQ-011 SHALL have port in_ready, output, 1: block accepts in_data this cycle.
REQ-012 SHALL have port out_data, output, AW*HIT: accumulated column; lane k is bits [AW*k +: AW].
REQ-013 SHALL have port out_valid, output, 1: out_data is valid.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts out_data.
REQ-015 SHALL have port frame_done, output, 1: one-cycle pulse when the last column of a frame is accepted downstream.
REQ-016 SHALL have port sat_o, output, 1: sticky per-frame saturation flag.

Function
REQ-017 SHALL accept a column ("beat") when in_valid && in_ready.
REQ-018 SHALL keep col_cnt (0..WID-1), advanced per beat, and ch_cnt (0..CHNL-1), advanced when col_cnt wraps from WID-1 to 0; both wrap to 0 after (WID-1, CHNL-1).
REQ-019 SHALL derive phase from ch_cnt: FIRST (ch_cnt==0), ACCUM (1..CHNL-2), LAST (CHNL-1).
REQ-020 SHALL keep a WID-entry column buffer of HIT*AW bits, indexed by col_cnt.
REQ-021 In FIRST, each beat SHALL overwrite buf[col_cnt] with the sign-extended input lanes; no buffer clear is needed between frames.
REQ-022 In ACCUM, each beat SHALL set buf[col_cnt] to buf[col_cnt] plus the sign-extended input, lane by lane.
REQ-023 In LAST, each beat SHALL load buf[col_cnt] plus the input into the out_data register, set out_valid on the next cycle (latency 1), and leave the buffer unchanged.
REQ-024 in_ready SHALL be 1 in FIRST and ACCUM; in LAST it SHALL be (!out_valid || out_ready).
REQ-025 out_valid SHALL clear on out_ready unless a new LAST beat is accepted in the same cycle; that case reloads out_data and out_valid stays 1.
REQ-026 While out_valid && !out_ready, out_data SHALL hold stable.
REQ-027 frame_done SHALL pulse for one cycle on the output handshake of column WID-1 of channel CHNL-1.
REQ-028 Without saturation, lane arithmetic SHALL wrap modulo 2^AW.
REQ-029 clr SHALL zero col_cnt, ch_cnt, out_valid and sat_o next cycle and ignore any beat in that cycle; it takes priority over all other events.
REQ-030 The buffer SHALL not need a reset.

Reset
REQ-031 On rst_n low, asynchronously: col_cnt=0, ch_cnt=0, out_valid=0, out_data=0, frame_done=0, sat_o=0.
REQ-032 Reset mid-frame SHALL discard partial sums; the next beat is treated as FIRST, column 0.

Configuration
REQ-033 Macro CHNL_ACUM_SAT_EN defined: each lane add in ACCUM and LAST SHALL clamp to [-2^(AW-1), 2^(AW-1)-1]; any clamp sets sat_o, which holds until frame_done, clr or reset.
REQ-034 Macro CHNL_ACUM_SAT_EN undefined: arithmetic wraps per REQ-028, and sat_o is tied 0.

Verification (DW=8, AW=12, HIT=2, WID=3, CHNL=4 unless stated)
REQ-035 Every lane fed 1 for 12 beats, out_ready=1 -> 3 outputs with all lanes 4; frame_done on the third; in_ready always 1.
REQ-036 Every lane fed -128 for all channels -> every output lane -512 (0xE00).
REQ-037 out_ready=0 during LAST -> first output held stable, in_ready=0 on the next LAST beat; out_ready=1 -> remaining outputs in order, none lost.
REQ-038 Back-to-back frames without clr: frame 1 all 1, frame 2 all 2 -> frame 2 outputs 8, no residue from frame 1.
REQ-039 AW=9, every lane fed 127 -> output 255 and sat_o=1 with CHNL_ACUM_SAT_EN; output -4 and sat_o=0 without it.
REQ-040 clr asserted after 5 beats -> out_valid=0; the next 12 beats of 1 produce outputs of 4.
